// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the CPU
// memory stage and the debug/loader port.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUED,
    HOLD
  } dbg_state_e;

  localparam int unsigned DMEM_ADDR_WIDTH = 14;
  localparam int unsigned DMEM_DATA_WIDTH = 32;
  localparam logic [3:0]  WBE_READ        = 4'b0000;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: CPU has priority, debug is forced through after
// STARVE_LIMIT consecutive lost arbitrations.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DMEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DMEM_DATA_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  input  logic [3:0]            cpu_req_wbe,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req_valid,
  output logic                  dbg_req_ready,
  input  logic [ADDR_WIDTH-1:0] dbg_req_addr,
  input  logic [DATA_WIDTH-1:0] dbg_req_wdata,
  input  logic [3:0]            dbg_req_wbe,
  output logic                  dbg_resp_valid,
  output logic [DATA_WIDTH-1:0] dbg_resp_data,
  input  logic                  dbg_resp_ready,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  dbg_state_e            state_q;
  logic [CNT_W-1:0]      starve_q;
  logic [DATA_WIDTH-1:0] resp_q;
  logic                  dbg_wr_q;
  logic                  cpu_rd_q;

  logic dbg_eligible;
  logic dbg_win;
  logic cpu_grant;

  // Grants are qualified by rst so nothing reaches memory in a reset cycle.
  assign dbg_eligible = rst && dbg_req_valid && (state_q == IDLE);
  assign dbg_win      = dbg_eligible && (!cpu_req_valid || (starve_q == CNT_MAX));
  assign cpu_grant    = rst && cpu_req_valid && !dbg_win;

  assign dbg_req_ready  = dbg_win;
  assign cpu_stall      = rst && cpu_req_valid && dbg_win;
  assign dbg_resp_valid = rst && (state_q == HOLD);
  assign dbg_resp_data  = rst ? resp_q : '0;
  assign cpu_rdata      = (rst && cpu_rd_q) ? mem_rdata : '0;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_win) begin
      mem_en    = 1'b1;
      mem_we    = dbg_req_wbe;
      mem_addr  = dbg_req_addr;
      mem_wdata = dbg_req_wdata;
    end else if (cpu_grant) begin
      mem_en    = 1'b1;
      mem_we    = cpu_req_wbe;
      mem_addr  = cpu_req_addr;
      mem_wdata = cpu_req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      resp_q   <= '0;
      dbg_wr_q <= 1'b0;
      cpu_rd_q <= 1'b0;
    end else begin
      cpu_rd_q <= cpu_grant && (cpu_req_wbe == WBE_READ);

      if (dbg_win || !dbg_req_valid) begin
        starve_q <= '0;
      end else if (dbg_eligible && (starve_q != CNT_MAX)) begin
        starve_q <= starve_q + 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (dbg_win) begin
            state_q  <= ISSUED;
            dbg_wr_q <= (dbg_req_wbe != WBE_READ);
          end
        end
        ISSUED: begin
          state_q <= HOLD;
          resp_q  <= dbg_wr_q ? '0 : mem_rdata;
        end
        HOLD: begin
          if (dbg_resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int unsigned AW    = 14;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req_valid;
  logic [AW-1:0] cpu_req_addr;
  logic [DW-1:0] cpu_req_wdata;
  logic [3:0]    cpu_req_wbe;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req_valid;
  logic          dbg_req_ready;
  logic [AW-1:0] dbg_req_addr;
  logic [DW-1:0] dbg_req_wdata;
  logic [3:0]    dbg_req_wbe;
  logic          dbg_resp_valid;
  logic [DW-1:0] dbg_resp_data;
  logic          dbg_resp_ready;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_req_wbe   (cpu_req_wbe),
    .cpu_stall     (cpu_stall),
    .cpu_rdata     (cpu_rdata),
    .dbg_req_valid (dbg_req_valid),
    .dbg_req_ready (dbg_req_ready),
    .dbg_req_addr  (dbg_req_addr),
    .dbg_req_wdata (dbg_req_wdata),
    .dbg_req_wbe   (dbg_req_wbe),
    .dbg_resp_valid(dbg_resp_valid),
    .dbg_resp_data (dbg_resp_data),
    .dbg_resp_ready(dbg_resp_ready),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  // Synchronous single-port memory standing in for the dmem instance.
  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= env_mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) env_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  function automatic logic [DW-1:0] pattern(input int i);
    return 32'hC0DE_0000 | DW'(i * 32'h0101);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [3:0]    be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    cpu_req_valid  = 1'b0;
    cpu_req_addr   = '0;
    cpu_req_wdata  = '0;
    cpu_req_wbe    = 4'h0;
    dbg_req_valid  = 1'b0;
    dbg_req_addr   = '0;
    dbg_req_wdata  = '0;
    dbg_req_wbe    = 4'h0;
    dbg_resp_ready = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_inputs();
      dbg_resp_ready = 1'b1;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cpu_req_valid = 1'b1; cpu_req_addr = 14'd7; cpu_req_wdata = 32'h1111_2222; cpu_req_wbe = 4'hF;
    dbg_req_valid = 1'b1; dbg_req_addr = 14'd8; dbg_req_wdata = 32'h3333_4444; dbg_req_wbe = 4'hF;
    dbg_resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en c%0d: got %b want 0", c, mem_en); end
      n_vec++; if (mem_we !== 4'h0) begin n_err++; $display("FAIL reset_mem_we c%0d: got %h want 0", c, mem_we); end
      n_vec++; if (dbg_req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready c%0d: got %b want 0", c, dbg_req_ready); end
      n_vec++; if (dbg_resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid c%0d: got %b want 0", c, dbg_resp_valid); end
      n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall c%0d: got %b want 0", c, cpu_stall); end
      n_vec++; if (cpu_rdata !== '0) begin n_err++; $display("FAIL reset_cpu_rdata c%0d: got %h want 0", c, cpu_rdata); end
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
  endtask

  task automatic test_cpu_only();
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_addr = 14'd0; cpu_req_wdata = 32'h1234_5678; cpu_req_wbe = 4'hF;
    #1;
    n_vec++; if (mem_en !== 1'b1 || mem_we !== 4'hF || mem_addr !== 14'd0 || mem_wdata !== 32'h1234_5678) begin
      n_err++; $display("FAIL cpu_write: got en=%b we=%h a=%h d=%h want 1 f 0 12345678", mem_en, mem_we, mem_addr, mem_wdata); end
    n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL cpu_write_stall: got %b want 0", cpu_stall); end
    @(negedge clk);
    cpu_req_wbe = 4'h0; cpu_req_wdata = '0;
    #1;
    n_vec++; if (mem_en !== 1'b1 || mem_we !== 4'h0 || cpu_stall !== 1'b0) begin
      n_err++; $display("FAIL cpu_read_issue: got en=%b we=%h stall=%b want 1 0 0", mem_en, mem_we, cpu_stall); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_vec++; if (cpu_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL cpu_rdata: got %h want 12345678", cpu_rdata); end
    @(negedge clk); #1;
    n_vec++; if (cpu_rdata !== '0) begin n_err++; $display("FAIL cpu_rdata_idle: got %h want 0", cpu_rdata); end
  endtask

  task automatic test_dbg_read();
    env_mem[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    dbg_req_valid = 1'b1; dbg_req_addr = 14'd1; dbg_req_wbe = 4'h0; dbg_resp_ready = 1'b0;
    #1;
    n_vec++; if (dbg_req_ready !== 1'b1 || mem_addr !== 14'd1 || mem_en !== 1'b1) begin
      n_err++; $display("FAIL dbg_handshake: got rdy=%b a=%h en=%b want 1 1 1", dbg_req_ready, mem_addr, mem_en); end
    @(negedge clk);
    dbg_req_valid = 1'b0;
    #1;
    n_vec++; if (dbg_resp_valid !== 1'b0) begin n_err++; $display("FAIL dbg_resp_early: got %b want 0", dbg_resp_valid); end
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      dbg_resp_ready = (k == 5);
      #1;
      n_vec++; if (dbg_resp_valid !== 1'b1 || dbg_resp_data !== 32'hDEAD_BEEF) begin
        n_err++; $display("FAIL dbg_resp_hold T+%0d: got v=%b d=%h want 1 deadbeef", k, dbg_resp_valid, dbg_resp_data); end
    end
    @(negedge clk);
    dbg_resp_ready = 1'b0;
    #1;
    n_vec++; if (dbg_resp_valid !== 1'b0) begin n_err++; $display("FAIL dbg_resp_consumed: got %b want 0", dbg_resp_valid); end
  endtask

  task automatic test_contention();
    env_mem[2] = 32'h2222_2222;
    env_mem[3] = 32'h3333_3333;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      cpu_req_valid = 1'b1; cpu_req_addr = 14'd2; cpu_req_wbe = 4'h0;
      dbg_req_valid = (k <= 5); dbg_req_addr = 14'd3; dbg_req_wbe = 4'h0; dbg_resp_ready = 1'b1;
      #1;
      n_vec++; if (dbg_req_ready !== (k == 5) || cpu_stall !== (k == 5)) begin
        n_err++; $display("FAIL contention k%0d: got rdy=%b stall=%b want %b %b", k, dbg_req_ready, cpu_stall, k == 5, k == 5); end
      n_vec++; if (mem_addr !== ((k == 5) ? 14'd3 : 14'd2)) begin
        n_err++; $display("FAIL contention_addr k%0d: got %h want %h", k, mem_addr, (k == 5) ? 14'd3 : 14'd2); end
      if (k >= 2) begin
        n_vec++; if (cpu_rdata !== ((k == 6) ? 32'h0 : 32'h2222_2222)) begin
          n_err++; $display("FAIL contention_rdata k%0d: got %h want %h", k, cpu_rdata, (k == 6) ? 32'h0 : 32'h2222_2222); end
      end
    end
    idle_cycles(3);
  endtask

  task automatic test_backpressure();
    env_mem[5] = 32'h5555_0005;
    @(negedge clk);
    dbg_req_valid = 1'b1; dbg_req_addr = 14'd4; dbg_req_wdata = 32'hAAAA_5555; dbg_req_wbe = 4'hF;
    #1;
    n_vec++; if (dbg_req_ready !== 1'b1) begin n_err++; $display("FAIL bp_first: got %b want 1", dbg_req_ready); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      dbg_req_wbe = 4'h0;
      cpu_req_valid = (k <= 5); cpu_req_addr = 14'd5; cpu_req_wbe = 4'h0;
      dbg_resp_ready = (k == 6);
      #1;
      n_vec++; if (dbg_req_ready !== 1'b0 || cpu_stall !== 1'b0) begin
        n_err++; $display("FAIL bp_blocked k%0d: got rdy=%b stall=%b want 0 0", k, dbg_req_ready, cpu_stall); end
      if (k >= 2) begin
        n_vec++; if (dbg_resp_valid !== 1'b1 || dbg_resp_data !== '0) begin
          n_err++; $display("FAIL bp_write_resp k%0d: got v=%b d=%h want 1 0", k, dbg_resp_valid, dbg_resp_data); end
        n_vec++; if (cpu_rdata !== 32'h5555_0005) begin
          n_err++; $display("FAIL bp_cpu_rdata k%0d: got %h want 55550005", k, cpu_rdata); end
      end
    end
    @(negedge clk);
    dbg_resp_ready = 1'b0;
    #1;
    n_vec++; if (dbg_req_ready !== 1'b1) begin n_err++; $display("FAIL bp_second: got %b want 1", dbg_req_ready); end
    @(negedge clk);
    dbg_req_valid = 1'b0;
    @(negedge clk);
    dbg_resp_ready = 1'b1;
    #1;
    n_vec++; if (dbg_resp_valid !== 1'b1 || dbg_resp_data !== 32'hAAAA_5555) begin
      n_err++; $display("FAIL bp_readback: got v=%b d=%h want 1 aaaa5555", dbg_resp_valid, dbg_resp_data); end
    idle_cycles(2);
  endtask

  task automatic test_reset_in_hold();
    env_mem[6] = 32'h6666_6666;
    @(negedge clk);
    dbg_req_valid = 1'b1; dbg_req_addr = 14'd1; dbg_req_wbe = 4'h0; dbg_resp_ready = 1'b0;
    @(negedge clk);
    dbg_req_valid = 1'b0;
    @(negedge clk); #1;
    n_vec++; if (dbg_resp_valid !== 1'b1) begin n_err++; $display("FAIL rih_hold: got %b want 1", dbg_resp_valid); end
    @(negedge clk);
    rst = 1'b0;
    dbg_req_valid = 1'b1; dbg_req_addr = 14'd6; dbg_req_wdata = 32'hBAD0_BAD0; dbg_req_wbe = 4'hF;
    #1;
    n_vec++; if (mem_en !== 1'b0 || dbg_req_ready !== 1'b0 || dbg_resp_valid !== 1'b0) begin
      n_err++; $display("FAIL rih_in_reset: got en=%b rdy=%b v=%b want 0 0 0", mem_en, dbg_req_ready, dbg_resp_valid); end
    @(negedge clk);
    rst = 1'b1;
    dbg_req_wbe = 4'h0;
    #1;
    n_vec++; if (dbg_resp_valid !== 1'b0 || dbg_req_ready !== 1'b1) begin
      n_err++; $display("FAIL rih_after: got v=%b rdy=%b want 0 1", dbg_resp_valid, dbg_req_ready); end
    @(negedge clk);
    dbg_req_valid = 1'b0;
    @(negedge clk);
    dbg_resp_ready = 1'b1;
    #1;
    n_vec++; if (dbg_resp_valid !== 1'b1 || dbg_resp_data !== 32'h6666_6666) begin
      n_err++; $display("FAIL rih_no_write: got v=%b d=%h want 1 66666666", dbg_resp_valid, dbg_resp_data); end
    idle_cycles(2);
  endtask

  // Model tracks memory contents, outstanding debug response with its due
  // cycle, and the number of consecutive arbitrations debug has lost.
  task automatic test_random();
    logic [DW-1:0] ref_mem [16];
    bit            outst, exp_rd, can, win, cpu_go;
    int            resp_at, losses;
    logic [DW-1:0] exp_resp, exp_rdata, e_wd;
    logic [3:0]    e_we;
    logic [AW-1:0] e_addr;
    bit            e_en, e_valid;
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = pattern(i);
      ref_mem[i] = pattern(i);
    end
    outst = 0; exp_rd = 0; losses = 0; resp_at = 0;
    exp_resp = '0; exp_rdata = '0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst            = (c >= 2) && ($urandom_range(0, 59) != 0);
      cpu_req_valid  = ($urandom_range(0, 2) != 0);
      cpu_req_addr   = AW'($urandom_range(0, 15));
      cpu_req_wdata  = $urandom;
      cpu_req_wbe    = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      dbg_req_valid  = ($urandom_range(0, 1) != 0);
      dbg_req_addr   = AW'($urandom_range(0, 15));
      dbg_req_wdata  = $urandom;
      dbg_req_wbe    = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      dbg_resp_ready = ($urandom_range(0, 2) == 0);
      #1;
      can    = rst && dbg_req_valid && !outst;
      win    = can && (!cpu_req_valid || losses == int'(LIMIT));
      cpu_go = rst && cpu_req_valid && !win;
      e_en = win || cpu_go;
      e_we = win ? dbg_req_wbe : (cpu_go ? cpu_req_wbe : 4'h0);
      e_addr = win ? dbg_req_addr : cpu_req_addr;
      e_wd = win ? dbg_req_wdata : cpu_req_wdata;
      e_valid = rst && outst && (c >= resp_at);
      n_vec++; if (mem_en !== e_en || mem_we !== e_we) begin
        n_err++; $display("FAIL rnd_mem_ctl c%0d: got en=%b we=%h want %b %h", c, mem_en, mem_we, e_en, e_we); end
      if (e_en) begin
        n_vec++; if (mem_addr !== e_addr || (e_we != 0 && mem_wdata !== e_wd)) begin
          n_err++; $display("FAIL rnd_mem_data c%0d: got a=%h d=%h want %h %h", c, mem_addr, mem_wdata, e_addr, e_wd); end
      end
      n_vec++; if (dbg_req_ready !== win || cpu_stall !== (cpu_req_valid && win)) begin
        n_err++; $display("FAIL rnd_grant c%0d: got rdy=%b stall=%b want %b %b", c, dbg_req_ready, cpu_stall, win, cpu_req_valid && win); end
      n_vec++; if (dbg_resp_valid !== e_valid) begin
        n_err++; $display("FAIL rnd_resp_valid c%0d: got %b want %b", c, dbg_resp_valid, e_valid); end
      if (e_valid) begin
        n_vec++; if (dbg_resp_data !== exp_resp) begin
          n_err++; $display("FAIL rnd_resp_data c%0d: got %h want %h", c, dbg_resp_data, exp_resp); end
      end
      n_vec++; if (cpu_rdata !== ((rst && exp_rd) ? exp_rdata : '0)) begin
        n_err++; $display("FAIL rnd_cpu_rdata c%0d: got %h want %h", c, cpu_rdata, (rst && exp_rd) ? exp_rdata : '0); end
      if (!rst) begin
        outst = 0; losses = 0; exp_rd = 0;
      end else begin
        if (win || !dbg_req_valid) losses = 0;
        else if (can && losses < int'(LIMIT)) losses++;
        if (e_valid && dbg_resp_ready) outst = 0;
        if (win) begin
          outst    = 1;
          resp_at  = c + 2;
          exp_resp = (dbg_req_wbe == 4'h0) ? ref_mem[dbg_req_addr[3:0]] : '0;
          ref_mem[dbg_req_addr[3:0]] = merge(ref_mem[dbg_req_addr[3:0]], dbg_req_wdata, dbg_req_wbe);
        end
        exp_rd = cpu_go && (cpu_req_wbe == 4'h0);
        if (cpu_go) begin
          exp_rdata = ref_mem[cpu_req_addr[3:0]];
          ref_mem[cpu_req_addr[3:0]] = merge(ref_mem[cpu_req_addr[3:0]], cpu_req_wdata, cpu_req_wbe);
        end
      end
    end
    idle_cycles(3);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_cpu_only();
    test_dbg_read();
    test_contention();
    test_backpressure();
    test_reset_in_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
